// File: rtl/rf_hazard_ctrl_pkg.sv
// rf_hazard_ctrl_pkg: shared register-file constants and the pending-counter width helper
package rf_hazard_ctrl_pkg;
  localparam int REG_ADDR_LEN = 3;
  localparam int REG_FILE_SIZE = 8;
  localparam int MAX_INFLIGHT = 3;
  localparam int R0 = 0;
  function automatic int cnt_w(input int max_cnt);
    return $clog2(max_cnt + 1);
  endfunction
endpackage

// File: rtl/rf_pend_cnt.sv
// rf_pend_cnt: per-register saturating pending-write counter
//   i_clk/i_rst  clock, synchronous active-high reset
//   i_inc        an accepted writer targets this register
//   i_dec        a writer to this register retires
//   o_cnt        registered pending count
//   o_underflow  retire seen while the count is already zero
module rf_pend_cnt import rf_hazard_ctrl_pkg::*; #(
  parameter int p_MAX = MAX_INFLIGHT,
  parameter int p_W = cnt_w(p_MAX)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_inc,
  input  logic           i_dec,
  output logic [p_W-1:0] o_cnt,
  output logic           o_underflow
);
  logic [p_W-1:0] cnt_q, cnt_d;
  logic up, dn;
  // simultaneous inc and dec cancel; a retire against zero leaves the count alone
  always_comb begin
    up = i_inc && !i_dec && cnt_q != p_W'(p_MAX);
    dn = i_dec && !i_inc && cnt_q != '0;
    cnt_d = up ? cnt_q + 1'b1 : dn ? cnt_q - 1'b1 : cnt_q;
    o_underflow = i_dec && cnt_q == '0;
  end
  always_ff @(posedge i_clk) cnt_q <= i_rst ? '0 : cnt_d;
  assign o_cnt = cnt_q;
endmodule

// File: rtl/rf_hazard_ctrl.sv
// rf_hazard_ctrl: register scoreboard and decode issue controller for the RiSC-16 register file
//   i_clk/i_rst                      clock, synchronous active-high reset
//   i_issue_valid, i_flush           decode handshake; flush kills the decode instruction
//   i_src1/2, i_src1/2_used          source registers and their use flags
//   i_tgt, i_tgt_we                  destination register and write enable
//   o_issue_ready                    combinational: no source hazard and target not saturated
//   i_ret_valid, i_ret_tgt           retire (writeback or squash) of an in-flight writer
//   o_busy_mask                      bit n = register n has pending writes (bit 0 always 0)
//   o_err                            sticky: retire to a register with nothing pending
// Optional macro RF_HAZARD_WB_BYPASS_EN: a source whose last pending writer retires
// this cycle is readable now, matching the register file's write-then-read behaviour.
module rf_hazard_ctrl import rf_hazard_ctrl_pkg::*; #(
  parameter int p_REG_ADDR_LEN = REG_ADDR_LEN,
  parameter int p_REG_FILE_SIZE = REG_FILE_SIZE,
  parameter int p_MAX_INFLIGHT = MAX_INFLIGHT
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_issue_valid,
  input  logic [p_REG_ADDR_LEN-1:0]  i_src1,
  input  logic [p_REG_ADDR_LEN-1:0]  i_src2,
  input  logic                       i_src1_used,
  input  logic                       i_src2_used,
  input  logic [p_REG_ADDR_LEN-1:0]  i_tgt,
  input  logic                       i_tgt_we,
  input  logic                       i_flush,
  output logic                       o_issue_ready,
  input  logic                       i_ret_valid,
  input  logic [p_REG_ADDR_LEN-1:0]  i_ret_tgt,
  output logic [p_REG_FILE_SIZE-1:0] o_busy_mask,
  output logic                       o_err
);
  localparam int CW = cnt_w(p_MAX_INFLIGHT);
  logic [CW-1:0] cnt [p_REG_FILE_SIZE];
  logic [p_REG_FILE_SIZE-1:1] uf;
  logic haz1, haz2, tgt_full, accept, err_q, err_d;
  assign cnt[R0] = '0;
  for (genvar g = 1; g < p_REG_FILE_SIZE; g++) begin : g_cnt
    rf_pend_cnt #(.p_MAX(p_MAX_INFLIGHT), .p_W(CW)) u_cnt (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_inc(accept && i_tgt_we && i_tgt == p_REG_ADDR_LEN'(g)),
      .i_dec(i_ret_valid && i_ret_tgt == p_REG_ADDR_LEN'(g)),
      .o_cnt(cnt[g]),
      .o_underflow(uf[g])
    );
  end
  // r0's counter is tied to zero, so r0 sources are never hazards and r0 targets never fill
  always_comb begin
    haz1 = i_src1_used && i_src1 != '0 && cnt[i_src1] != '0;
    haz2 = i_src2_used && i_src2 != '0 && cnt[i_src2] != '0;
`ifdef RF_HAZARD_WB_BYPASS_EN
    haz1 = haz1 && !(i_ret_valid && i_ret_tgt == i_src1 && cnt[i_src1] == CW'(1));
    haz2 = haz2 && !(i_ret_valid && i_ret_tgt == i_src2 && cnt[i_src2] == CW'(1));
`endif
    tgt_full = i_tgt_we && i_tgt != '0 && cnt[i_tgt] == CW'(p_MAX_INFLIGHT);
    o_issue_ready = !haz1 && !haz2 && !tgt_full;
    accept = i_issue_valid && o_issue_ready && !i_flush;
    err_d = err_q || |uf;
    for (int n = 0; n < p_REG_FILE_SIZE; n++) o_busy_mask[n] = cnt[n] != '0;
  end
  always_ff @(posedge i_clk) err_q <= i_rst ? 1'b0 : err_d;
  assign o_err = err_q;
endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// tb_rf_hazard_ctrl: table-driven check of rf_hazard_ctrl with a scoreboard queue for registered outputs
module tb_rf_hazard_ctrl;
`ifdef RF_HAZARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, v, u1, u2, we, fl, rv, rdy, err;
  logic [2:0] s1, s2, t, rt;
  logic [7:0] busy;
  rf_hazard_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_issue_valid(v),
    .i_src1(s1), .i_src2(s2), .i_src1_used(u1), .i_src2_used(u2),
    .i_tgt(t), .i_tgt_we(we), .i_flush(fl), .o_issue_ready(rdy),
    .i_ret_valid(rv), .i_ret_tgt(rt), .o_busy_mask(busy), .o_err(err)
  );
  typedef struct {
    bit rst, v; int s1; bit u1; int s2; bit u2; int t; bit we, fl, rv; int rt;
    bit rdy; int busy; bit err;
  } vec_t;
  typedef struct { logic [7:0] busy; logic err; } exp_t;
  vec_t tv[$];
  exp_t sb[$];
  int pass_cnt = 0, tot_cnt = 0;
  function automatic vec_t mk(bit r, bit vv, int a, bit ua, int b, bit ub, int tt, bit w, bit f,
                              bit rr, int rtt, bit erdy, int ebusy, bit eerr);
    vec_t x;
    x.rst = r; x.v = vv; x.s1 = a; x.u1 = ua; x.s2 = b; x.u2 = ub; x.t = tt; x.we = w;
    x.fl = f; x.rv = rr; x.rt = rtt; x.rdy = erdy; x.busy = ebusy; x.err = eerr;
    return x;
  endfunction
  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask
  task automatic idle();
    rst = 0; v = 0; s1 = 0; u1 = 0; s2 = 0; u2 = 0; t = 0; we = 0; fl = 0; rv = 0; rt = 0;
  endtask
  task automatic apply(int idx, vec_t x);
    exp_t e;
    @(negedge clk);
    rst = x.rst; v = x.v; s1 = 3'(x.s1); u1 = x.u1; s2 = 3'(x.s2); u2 = x.u2;
    t = 3'(x.t); we = x.we; fl = x.fl; rv = x.rv; rt = 3'(x.rt);
    #1 chk("ready", idx, 32'(rdy), 32'(x.rdy));
    sb.push_back('{8'(x.busy), x.err});
    @(posedge clk);
    #1 e = sb.pop_front();
    chk("busy", idx, 32'(busy), 32'(e.busy));
    chk("err", idx, 32'(err), 32'(e.err));
  endtask
  initial begin
    int lat;
    idle();
    //          rst v  s1 u1 s2 u2 t  we fl rv rt  rdy busy  err
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0));
    tv.push_back(mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 'h08, 0));
    tv.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h08, 0));
    tv.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 1, 3, BYP, 'h00, 0));
    tv.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 'h20, 0));
    tv.push_back(mk(0, 1, 5, 0, 0, 0, 5, 1, 0, 0, 0, 1, 'h20, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 'h20, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 'h20, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 5, 0, 'h20, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 'h20, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 5, 1, 0, 1, 5, 0, 'h20, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 'h20, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 'h00, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 1, 'h00, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 'h10, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 1, 4, 1, 'h10, 0));
    tv.push_back(mk(0, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 'h10, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 'h00, 0));
    tv.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 'h00, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 'h00, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 1));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 1, 'h40, 1));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 'h80, 0));
    foreach (tv[i]) apply(i, tv[i]);
    // retire r7 while reading it: measure cycles until decode may proceed
    @(negedge clk);
    idle(); v = 1; s1 = 7; u1 = 1; rv = 1; rt = 7;
    lat = -1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rdy) begin lat = c; break; end
      @(negedge clk);
      rv = 0;
    end
    chk("wb_latency", 100, 32'(lat), BYP ? 32'd0 : 32'd1);
    @(posedge clk);
    #1 idle();
    @(posedge clk);
    #1 chk("busy_after_wb", 101, 32'(busy), 32'h0);
    chk("err_after_wb", 102, 32'(err), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
